// File: rtl/por_seq_pkg.sv
// Shared definitions for the power-on reset sequencer: default widths, the
// sequencer state encoding and the per-stage delay slice helper.
package por_seq_pkg;

    // Default geometry of the sequencer.
    localparam int unsigned DefNRails     = 2;
    localparam int unsigned DefNStages    = 3;
    localparam int unsigned DefSyncStages = 2;
    localparam int unsigned DefFiltW      = 8;
    localparam int unsigned DefDlyW       = 16;
    localparam int unsigned DefTmoW       = 20;

    // Widest stage_dly bus the slice helper can handle.
    localparam int unsigned MaxDlyBusW = 256;

    // Sequencer state encoding; the values are visible on seq_state.
    typedef logic [2:0] seq_state_t;
    localparam seq_state_t StIdle      = 3'd0;
    localparam seq_state_t StWaitRails = 3'd1;
    localparam seq_state_t StRelease   = 3'd2;
    localparam seq_state_t StRun       = 3'd3;
    localparam seq_state_t StFault     = 3'd4;

    // Returns the delay of stage k in the low dly_w bits; caller truncates.
    function automatic logic [MaxDlyBusW-1:0] stage_dly_slice(
        input logic [MaxDlyBusW-1:0] bus,
        input int unsigned           dly_w,
        input int unsigned           k
    );
        return bus >> (k * dly_w);
    endfunction

endpackage

// File: rtl/por_rail_filt.sv
// One supply rail: multi-flop synchroniser followed by an asymmetric debounce
// (slow, counted rise; immediate fall).
module por_rail_filt
    import por_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefSyncStages,
    parameter int unsigned FILT_W      = DefFiltW
) (
    input  logic              osc_ck,
    input  logic              por,
    input  logic              pwup_in,
    input  logic [FILT_W-1:0] filt_thr,
    output logic              pwup_filt_d,
    output logic              pwup_filt
);

    logic [SYNC_STAGES-1:0] sync_d, sync_q;
    logic [FILT_W-1:0]      cnt_d, cnt_q;
    logic                   filt_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Shift the raw comparator output into the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pwup_in};
    end

    // Count consecutive synced-high cycles (saturating); any low clears at once.
    always_comb begin
        cnt_d       = '0;
        pwup_filt_d = 1'b0;
        if (synced) begin
            cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + FILT_W'(1);
            pwup_filt_d = (cnt_d >= filt_thr);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge osc_ck) begin
        if (por) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= pwup_filt_d;
        end
    end

    assign pwup_filt = filt_q;

endmodule

// File: rtl/por_reset_seq.sv
// Power-on reset sequencer: debounces N_RAILS power-good inputs, then releases
// N_STAGES reset domains in order with per-stage delays. Handles startup
// timeout (sticky fault) and brownout (abort and re-sequence).
module por_reset_seq
    import por_seq_pkg::*;
#(
    parameter int unsigned N_RAILS     = DefNRails,
    parameter int unsigned N_STAGES    = DefNStages,
    parameter int unsigned SYNC_STAGES = DefSyncStages,
    parameter int unsigned FILT_W      = DefFiltW,
    parameter int unsigned DLY_W       = DefDlyW,
    parameter int unsigned TMO_W       = DefTmoW
) (
    input  logic                      osc_ck,
    input  logic                      por,
    input  logic [N_RAILS-1:0]        pwup_in,
    input  logic [N_RAILS-1:0]        rail_en,
    input  logic [FILT_W-1:0]         filt_cnt,
    input  logic [N_STAGES*DLY_W-1:0] stage_dly,
    input  logic [TMO_W-1:0]          startup_tmo,
    input  logic                      force_short_oneshot,
    output logic [N_STAGES-1:0]       rst_out,
    output logic [N_RAILS-1:0]        pwup_filt,
    output logic                      all_good,
    output logic                      startup_timed_out,
    output logic                      brownout,
    output logic [2:0]                seq_state
);

    localparam int unsigned     IdxW    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_STAGES - 1);

    logic [FILT_W-1:0]     filt_thr;
    logic [N_RAILS-1:0]    pwup_filt_d;
    logic                  all_good_d, all_good_q;
    seq_state_t            state_d, state_q;
    logic [IdxW-1:0]       idx_d, idx_q;
    logic [DLY_W-1:0]      dly_d, dly_q;
    logic [TMO_W-1:0]      tmo_d, tmo_q, tmo_inc;
    logic [N_STAGES-1:0]   rst_d, rst_q;
    logic                  timed_out_d, timed_out_q;
    logic                  brownout_d, brownout_q;
    logic [MaxDlyBusW-1:0] dly_bus;
    logic [DLY_W-1:0]      dly_first, dly_next;

    // Debounce threshold: zero behaves as one; the debug shortcut forces one.
    always_comb begin
        filt_thr = filt_cnt;
        if (force_short_oneshot || (filt_cnt == '0)) begin
            filt_thr = FILT_W'(1);
        end
    end

    for (genvar r = 0; r < N_RAILS; r++) begin : g_rail
        por_rail_filt #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_W     (FILT_W)
        ) u_filt (
            .osc_ck     (osc_ck),
            .por        (por),
            .pwup_in    (pwup_in[r]),
            .filt_thr   (filt_thr),
            .pwup_filt_d(pwup_filt_d[r]),
            .pwup_filt  (pwup_filt[r])
        );
    end

    // The FSM looks at the next filter value so it reacts on the same edge
    // that the registered all_good flag changes.
    assign all_good_d = &(pwup_filt_d | ~rail_en);
    assign dly_bus    = MaxDlyBusW'(stage_dly);
    assign tmo_inc    = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);

    // Stage delays are fetched at load time; the debug shortcut zeroes them.
    always_comb begin
        dly_first = DLY_W'(stage_dly_slice(dly_bus, DLY_W, 0));
        dly_next  = DLY_W'(stage_dly_slice(dly_bus, DLY_W, 32'(idx_q) + 1));
        if (force_short_oneshot) begin
            dly_first = '0;
            dly_next  = '0;
        end
    end

    // Sequencer next-state: rail wait, staged release, run and fault handling.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dly_d       = dly_q;
        tmo_d       = tmo_q;
        rst_d       = rst_q;
        timed_out_d = timed_out_q;
        brownout_d  = brownout_q;
        unique case (state_q)
            StIdle: begin
                tmo_d   = '0;
                rst_d   = '1;
                state_d = StWaitRails;
            end
            StWaitRails: begin
                rst_d = '1;
                tmo_d = tmo_inc;
                if (all_good_d) begin
                    idx_d   = '0;
                    dly_d   = dly_first;
                    state_d = StRelease;
                end else if ((startup_tmo != '0) && (tmo_inc >= startup_tmo)) begin
                    timed_out_d = 1'b1;
                    state_d     = StFault;
                end
            end
            StRelease: begin
                if (!all_good_d) begin
                    // Rail lost mid-sequence: restart without flagging brownout.
                    rst_d   = '1;
                    idx_d   = '0;
                    tmo_d   = '0;
                    state_d = StWaitRails;
                end else if ((dly_q == '0) || force_short_oneshot) begin
                    rst_d[idx_q] = 1'b0;
                    if (idx_q == LastIdx) begin
                        state_d = StRun;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                        dly_d = dly_next;
                    end
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            StRun: begin
                if (!all_good_d) begin
                    brownout_d = 1'b1;
                    rst_d      = '1;
                    idx_d      = '0;
                    tmo_d      = '0;
                    state_d    = StWaitRails;
                end
            end
            StFault: begin
                rst_d = '1;
            end
            default: begin
                rst_d   = '1;
                state_d = StIdle;
            end
        endcase
    end

    // Sequencer registers with synchronous reset.
    always_ff @(posedge osc_ck) begin
        if (por) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            dly_q       <= '0;
            tmo_q       <= '0;
            rst_q       <= '1;
            timed_out_q <= 1'b0;
            brownout_q  <= 1'b0;
            all_good_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dly_q       <= dly_d;
            tmo_q       <= tmo_d;
            rst_q       <= rst_d;
            timed_out_q <= timed_out_d;
            brownout_q  <= brownout_d;
            all_good_q  <= all_good_d;
        end
    end

    assign rst_out           = rst_q;
    assign all_good          = all_good_q;
    assign startup_timed_out = timed_out_q;
    assign brownout          = brownout_q;
    assign seq_state         = state_q;

endmodule

// File: tb/tb_por_reset_seq.sv
// Self-checking bench for por_reset_seq: directed scenarios plus a randomized
// soak, every cycle compared against a behavioural model of the sequencer.
module tb_por_reset_seq;

    localparam int unsigned NR = 2;
    localparam int unsigned NS = 3;
    localparam int unsigned SS = 2;
    localparam int unsigned FW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned TW = 20;

    logic              osc_ck = 1'b0;
    logic              por;
    logic [NR-1:0]     pwup_in;
    logic [NR-1:0]     rail_en;
    logic [FW-1:0]     filt_cnt;
    logic [NS*DW-1:0]  stage_dly;
    logic [TW-1:0]     startup_tmo;
    logic              force_short_oneshot;
    logic [NS-1:0]     rst_out;
    logic [NR-1:0]     pwup_filt;
    logic              all_good;
    logic              startup_timed_out;
    logic              brownout;
    logic [2:0]        seq_state;

    por_reset_seq #(
        .N_RAILS    (NR),
        .N_STAGES   (NS),
        .SYNC_STAGES(SS),
        .FILT_W     (FW),
        .DLY_W      (DW),
        .TMO_W      (TW)
    ) dut (
        .osc_ck             (osc_ck),
        .por                (por),
        .pwup_in            (pwup_in),
        .rail_en            (rail_en),
        .filt_cnt           (filt_cnt),
        .stage_dly          (stage_dly),
        .startup_tmo        (startup_tmo),
        .force_short_oneshot(force_short_oneshot),
        .rst_out            (rst_out),
        .pwup_filt          (pwup_filt),
        .all_good           (all_good),
        .startup_timed_out  (startup_timed_out),
        .brownout           (brownout),
        .seq_state          (seq_state)
    );

    always #5 osc_ck = ~osc_ck;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: phases use the published seq_state values.
    localparam int PhIdle = 0, PhWait = 1, PhRelease = 2, PhRun = 3, PhFault = 4;

    bit            hist [NR][SS];   // raw input history, [0] = newest
    int            run_len [NR];    // consecutive synced-high cycles
    int            rel_at [NS];     // release time of each stage, from RELEASE entry
    logic [NR-1:0] m_filt;
    logic          m_ag;
    int            m_phase;
    int            m_tmo;
    int            m_el;
    logic [NS-1:0] m_rst;
    logic          m_to;
    logic          m_bo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_restart();
        m_phase = PhWait;
        m_tmo   = 0;
        m_rst   = '1;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        int thr;
        int acc;
        if (por) begin
            for (int r = 0; r < NR; r++) begin
                run_len[r] = 0;
                for (int s = 0; s < SS; s++) hist[r][s] = 1'b0;
            end
            m_filt  = '0;
            m_ag    = 1'b0;
            m_phase = PhIdle;
            m_tmo   = 0;
            m_el    = 0;
            m_rst   = '1;
            m_to    = 1'b0;
            m_bo    = 1'b0;
            return;
        end
        thr = (force_short_oneshot || filt_cnt == '0) ? 1 : int'(filt_cnt);
        for (int r = 0; r < NR; r++) begin
            bit seen;
            seen = hist[r][SS-1];
            for (int s = SS - 1; s > 0; s--) hist[r][s] = hist[r][s-1];
            hist[r][0] = pwup_in[r];
            run_len[r] = seen ? ((run_len[r] < (1 << FW) - 1) ? run_len[r] + 1 : run_len[r]) : 0;
            m_filt[r]  = seen && (run_len[r] >= thr);
        end
        m_ag = &(m_filt | ~rail_en);
        case (m_phase)
            PhIdle: begin
                m_phase = PhWait;
                m_tmo   = 0;
            end
            PhWait: begin
                m_tmo++;
                if (m_ag) begin
                    acc = 0;
                    for (int k = 0; k < NS; k++) begin
                        acc += (force_short_oneshot ? 0 : int'(stage_dly[k*DW +: DW])) + 1;
                        rel_at[k] = acc;
                    end
                    m_el    = 0;
                    m_phase = PhRelease;
                end else if (startup_tmo != '0 && m_tmo >= int'(startup_tmo)) begin
                    m_to    = 1'b1;
                    m_phase = PhFault;
                end
            end
            PhRelease: begin
                if (!m_ag) begin
                    m_restart();
                end else begin
                    m_el++;
                    for (int k = 0; k < NS; k++) m_rst[k] = (m_el < rel_at[k]);
                    if (m_el == rel_at[NS-1]) m_phase = PhRun;
                end
            end
            PhRun: begin
                if (!m_ag) begin
                    m_bo = 1'b1;
                    m_restart();
                end
            end
            default: ;
        endcase
    endtask

    // One clock: update the model at the edge, compare all outputs just after.
    task automatic cyc();
        @(posedge osc_ck);
        model_step();
        #1;
        check("rst_out", 32'(rst_out), 32'(m_rst));
        check("pwup_filt", 32'(pwup_filt), 32'(m_filt));
        check("all_good", 32'(all_good), 32'(m_ag));
        check("startup_timed_out", 32'(startup_timed_out), 32'(m_to));
        check("brownout", 32'(brownout), 32'(m_bo));
        check("seq_state", 32'(seq_state), 32'(m_phase));
    endtask

    task automatic wait_fall(input int b, output int n);
        n = 0;
        while (rst_out[b] !== 1'b0 && n < 100) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (seq_state !== 3'd3 && n < 200) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int n, n0, n1, n2, len, r;

        // Reset values.
        por                 = 1'b1;
        pwup_in             = '0;
        rail_en             = '1;
        filt_cnt            = 8'd4;
        stage_dly           = {16'd3, 16'd1, 16'd0};
        startup_tmo         = '0;
        force_short_oneshot = 1'b0;
        repeat (4) cyc();
        check("reset_rst_out", 32'(rst_out), 32'h7);
        check("reset_seq_state", 32'(seq_state), 32'h0);

        // Normal release: filter latency 2 sync + 4 debounce, then gaps 1/2/4.
        por = 1'b0;
        repeat (3) cyc();
        pwup_in = '1;
        n = 0;
        while (pwup_filt !== 2'b11 && n < 50) begin
            cyc();
            n++;
        end
        check("filt_rise_latency", 32'(n), 32'd6);
        wait_fall(0, n0);
        wait_fall(1, n1);
        wait_fall(2, n2);
        check("release0_gap", 32'(n0), 32'd1);
        check("release1_gap", 32'(n1), 32'd2);
        check("release2_gap", 32'(n2), 32'd4);
        check("normal_run_state", 32'(seq_state), 32'd3);

        // Glitches shorter than the debounce count never qualify rail1.
        por     = 1'b1;
        pwup_in = 2'b01;
        repeat (2) cyc();
        por = 1'b0;
        repeat (3) cyc();
        for (int i = 0; i < 5; i++) begin
            filt_cnt = (i == 0) ? 8'd4 : FW'($urandom_range(2, 8));
            len      = (i == 0) ? 3 : int'($urandom_range(1, int'(filt_cnt) - 1));
            pwup_in[1] = 1'b1;
            repeat (len) cyc();
            pwup_in[1] = 1'b0;
            repeat (6) cyc();
            check("glitch_filt1", 32'(pwup_filt[1]), 32'd0);
            check("glitch_rst_out", 32'(rst_out), 32'h7);
        end

        // Brownout in RUN: one-cycle dip on rail0.
        filt_cnt = 8'd4;
        pwup_in  = '1;
        wait_run(n);
        check("pre_brownout_run", 32'(seq_state), 32'd3);
        pwup_in[0] = 1'b0;
        cyc();
        pwup_in[0] = 1'b1;
        n = 1;
        while (rst_out !== 3'b111 && n < 20) begin
            cyc();
            n++;
        end
        check("brownout_latency", 32'(n), 32'(SS + 1));
        check("brownout_flag", 32'(brownout), 32'd1);
        wait_run(n);
        check("resequence_rst_out", 32'(rst_out), 32'h0);
        check("brownout_sticky", 32'(brownout), 32'd1);

        // Startup timeout: rail1 never comes up.
        por         = 1'b1;
        pwup_in     = 2'b01;
        startup_tmo = TW'(100);
        repeat (2) cyc();
        por = 1'b0;
        n = 0;
        while (startup_timed_out !== 1'b1 && n < 300) begin
            cyc();
            n++;
        end
        // One IDLE cycle, then 100 cycles in WAIT_RAILS.
        check("timeout_cycle", 32'(n), 32'd101);
        check("fault_state", 32'(seq_state), 32'd4);
        pwup_in = '1;
        repeat (30) cyc();
        check("fault_hold_rst", 32'(rst_out), 32'h7);
        check("fault_hold_state", 32'(seq_state), 32'd4);
        por = 1'b1;
        cyc();
        check("fault_cleared", 32'(startup_timed_out), 32'd0);

        // Masked rail1 with debug shortcut: release in N_STAGES cycles.
        startup_tmo         = '0;
        rail_en             = 2'b01;
        pwup_in             = '0;
        force_short_oneshot = 1'b1;
        stage_dly           = '1;
        filt_cnt            = FW'($urandom_range(2, 255));
        cyc();
        por = 1'b0;
        repeat (3) cyc();
        pwup_in[0] = 1'b1;
        n = 0;
        while (pwup_filt[0] !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        check("force_filt_latency", 32'(n), 32'(SS + 1));
        n = 0;
        while (rst_out !== 3'b000 && n < 20) begin
            cyc();
            n++;
        end
        check("force_release_cycles", 32'(n), 32'(NS));

        // Randomized soak against the model.
        for (int ep = 0; ep < 8; ep++) begin
            por = 1'b1;
            for (int k = 0; k < NS; k++) stage_dly[k*DW +: DW] = DW'($urandom_range(0, 6));
            filt_cnt            = FW'($urandom_range(0, 6));
            startup_tmo         = ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom_range(30, 120));
            rail_en             = NR'($urandom_range(0, 3));
            force_short_oneshot = ($urandom_range(0, 3) == 0);
            pwup_in             = NR'($urandom_range(0, 3));
            repeat (2) cyc();
            por = 1'b0;
            for (int c = 0; c < 250; c++) begin
                if ($urandom_range(0, 9) == 0) begin
                    r = int'($urandom_range(0, NR - 1));
                    pwup_in[r] = ~pwup_in[r];
                end
                if ($urandom_range(0, 59) == 0) filt_cnt = FW'($urandom_range(0, 6));
                if ($urandom_range(0, 99) == 0) rail_en = NR'($urandom_range(0, 3));
                cyc();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
